// File: rtl/plot_pkg.sv
// Shared types and screen geometry for the plot buffer and its FIFO.
package plot_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;

    typedef logic signed [8:0] coord_x_t;
    typedef logic signed [7:0] coord_y_t;

    typedef struct packed {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] colour;
    } plot_t;

endpackage

// File: rtl/plot_fifo.sv
// Synchronous FIFO of plot_t entries; clear has priority over push and pop.
module plot_fifo
    import plot_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_clear,
    input  logic                     i_push,
    input  plot_t                    i_wdata,
    input  logic                     i_pop,
    output plot_t                    o_head,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    plot_t          r_mem [DEPTH];
    logic [PW-1:0]  r_wr_ptr;
    logic [PW-1:0]  r_rd_ptr;
    logic [CW-1:0]  r_count;
    logic           w_wr;
    logic           w_rd;

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_head  = r_mem[r_rd_ptr];

    assign w_wr = i_push && !o_full && !i_clear;
    assign w_rd = i_pop && !o_empty && !i_clear;

    // Storage is left unreset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/vga_plot_buffer.sv
// Clipping, buffered plot front-end for the VGA adapter.
// Define PLOT_CLIP_EN to drop off-screen requests and count them in clip_cnt.
module vga_plot_buffer
    import plot_pkg::*;
#(
    parameter int DEPTH    = 8,
    parameter int SCREEN_W = plot_pkg::SCREEN_W,
    parameter int SCREEN_H = plot_pkg::SCREEN_H
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  coord_x_t    in_x,
    input  coord_y_t    in_y,
    input  logic [2:0]  in_colour,
    output logic        in_ready,
    input  logic        flush,
    input  logic        out_en,
    output logic [7:0]  vga_x,
    output logic [6:0]  vga_y,
    output logic [2:0]  vga_colour,
    output logic        vga_plot,
    output logic        idle,
    output logic [15:0] clip_cnt
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [CW-1:0] w_count;
    logic          w_full;
    logic          w_empty;
    plot_t         w_head;
    plot_t         w_req;
    logic          w_onscreen;
    logic          w_accept;
    logic          w_push_req;
    logic          w_pop;
    logic          w_bypass;
    logic          w_push;
    plot_t         r_out;
    logic          r_plot;

    // Ready depends only on occupancy so a full FIFO refuses even on a pop edge.
    assign in_ready   = rst_n && !w_full;
    assign w_accept   = in_valid && in_ready && !flush;
    assign w_req      = '{x: in_x[7:0], y: in_y[6:0], colour: in_colour};
    assign w_push_req = w_accept && w_onscreen;
    assign w_pop      = out_en && !w_empty && !flush;
    assign w_bypass   = out_en && w_empty && w_push_req;
    assign w_push     = w_push_req && !w_bypass;

`ifdef PLOT_CLIP_EN
    logic [15:0] r_clip_cnt;

    assign w_onscreen = (int'(in_x) >= 0) && (int'(in_x) < SCREEN_W) &&
                        (int'(in_y) >= 0) && (int'(in_y) < SCREEN_H);
    assign clip_cnt   = r_clip_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_clip_cnt <= '0;
        end else if (w_accept && !w_onscreen && (r_clip_cnt != 16'hFFFF)) begin
            r_clip_cnt <= r_clip_cnt + 16'd1;
        end
    end
`else
    logic [1:0]  w_unused_bits;
    logic [31:0] w_unused_dims;

    assign w_onscreen    = 1'b1;
    assign clip_cnt      = '0;
    assign w_unused_bits = {in_x[8], in_y[7]};
    assign w_unused_dims = SCREEN_W + SCREEN_H;
`endif

    plot_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clear (flush),
        .i_push  (w_push),
        .i_wdata (w_req),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Queued entries always drain before a new request may bypass the FIFO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out  <= '0;
            r_plot <= 1'b0;
        end else if (flush || !out_en) begin
            r_plot <= 1'b0;
        end else if (w_pop) begin
            r_out  <= w_head;
            r_plot <= 1'b1;
        end else if (w_bypass) begin
            r_out  <= w_req;
            r_plot <= 1'b1;
        end else begin
            r_plot <= 1'b0;
        end
    end

    logic [CW-1:0] w_unused_count;
    assign w_unused_count = w_count;

    assign vga_x      = r_out.x;
    assign vga_y      = r_out.y;
    assign vga_colour = r_out.colour;
    assign vga_plot   = r_plot;
    assign idle       = w_empty && !r_plot;

endmodule

// File: tb/tb_vga_plot_buffer.sv
// Directed self-checking bench for vga_plot_buffer; expectations follow PLOT_CLIP_EN.
module tb_vga_plot_buffer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [8:0]  in_x;
    logic [7:0]  in_y;
    logic [2:0]  in_colour;
    logic        in_ready;
    logic        flush;
    logic        out_en;
    logic [7:0]  vga_x;
    logic [6:0]  vga_y;
    logic [2:0]  vga_colour;
    logic        vga_plot;
    logic        idle;
    logic [15:0] clip_cnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    vga_plot_buffer #(.DEPTH(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_x       (in_x),
        .in_y       (in_y),
        .in_colour  (in_colour),
        .in_ready   (in_ready),
        .flush      (flush),
        .out_en     (out_en),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .vga_colour (vga_colour),
        .vga_plot   (vga_plot),
        .idle       (idle),
        .clip_cnt   (clip_cnt)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Inputs change after a falling edge; outputs are observed at the next falling edge.
    task automatic applyStimulus(input logic v, input int x, input int y, input int c);
        in_valid  = v;
        in_x      = x[8:0];
        in_y      = y[7:0];
        in_colour = c[2:0];
        @(posedge clk);
        @(negedge clk);
    endtask

    int expPlot [4];
    int expX    [4];
    int expY    [4];
    int expClip;
    int pulses, readyLow, streamBad, firstX, firstY, lastX, lastY;
    int sx, sy;

    initial begin
        rst_n = 1'b1; in_valid = 1'b0; in_x = '0; in_y = '0; in_colour = '0;
        flush = 1'b0; out_en = 1'b0;
`ifdef PLOT_CLIP_EN
        expPlot = '{0, 0, 0, 1};
        expX    = '{0, 0, 0, 159};
        expY    = '{0, 0, 0, 119};
        expClip = 3;
`else
        expPlot = '{1, 1, 1, 1};
        expX    = '{255, 160, 5, 159};
        expY    = '{5, 5, 120, 119};
        expClip = 0;
`endif
        #1 rst_n = 1'b0;
        #2;
        checkOutput("reset_ready", in_ready, 0);
        checkOutput("reset_x", vga_x, 0);
        checkOutput("reset_y", vga_y, 0);
        checkOutput("reset_colour", vga_colour, 0);
        checkOutput("reset_plot", vga_plot, 0);
        checkOutput("reset_idle", idle, 1);
        checkOutput("reset_clip", clip_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("ready_after_reset", in_ready, 1);

        // Single plot through the bypass path
        out_en = 1'b1;
        applyStimulus(1'b1, 10, 20, 3);
        checkOutput("single_plot", vga_plot, 1);
        checkOutput("single_x", vga_x, 10);
        checkOutput("single_y", vga_y, 20);
        checkOutput("single_colour", vga_colour, 3);
        applyStimulus(1'b0, 0, 0, 0);
        checkOutput("single_plot_end", vga_plot, 0);
        checkOutput("single_idle", idle, 1);

        // Clipping boundary requests
        applyStimulus(1'b1, -1, 5, 1);
        checkOutput("clip0_plot", vga_plot, expPlot[0]);
        if (expPlot[0] == 1) checkOutput("clip0_x", vga_x, expX[0]);
        applyStimulus(1'b1, 160, 5, 2);
        checkOutput("clip1_plot", vga_plot, expPlot[1]);
        if (expPlot[1] == 1) checkOutput("clip1_x", vga_x, expX[1]);
        applyStimulus(1'b1, 5, 120, 4);
        checkOutput("clip2_plot", vga_plot, expPlot[2]);
        if (expPlot[2] == 1) checkOutput("clip2_y", vga_y, expY[2]);
        applyStimulus(1'b1, 159, 119, 6);
        checkOutput("clip3_plot", vga_plot, expPlot[3]);
        checkOutput("clip3_x", vga_x, expX[3]);
        checkOutput("clip3_y", vga_y, expY[3]);
        checkOutput("clip3_colour", vga_colour, 6);
        checkOutput("clip_cnt", clip_cnt, expClip);
        applyStimulus(1'b0, 0, 0, 0);
        checkOutput("clip_end_plot", vga_plot, 0);

        // Backpressure: nine pushes with the drain paused
        out_en = 1'b0;
        for (int i = 0; i < 9; i++) begin
            checkOutput($sformatf("bp_ready_%0d", i), in_ready, (i < 8) ? 1 : 0);
            applyStimulus(1'b1, i, i + 1, i % 8);
        end
        checkOutput("bp_full_ready", in_ready, 0);
        checkOutput("bp_full_idle", idle, 0);
        checkOutput("bp_full_plot", vga_plot, 0);
        out_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, 0, 0, 0);
            checkOutput($sformatf("bp_plot_%0d", i), vga_plot, 1);
            checkOutput($sformatf("bp_x_%0d", i), vga_x, i);
            checkOutput($sformatf("bp_y_%0d", i), vga_y, i + 1);
            checkOutput($sformatf("bp_colour_%0d", i), vga_colour, i % 8);
            if (i == 0) checkOutput("bp_ready_after_pop", in_ready, 1);
        end
        applyStimulus(1'b0, 0, 0, 0);
        checkOutput("bp_drained_plot", vga_plot, 0);
        checkOutput("bp_drained_idle", idle, 1);

        // Flush with four entries queued and a request presented
        out_en = 1'b0;
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 20 + i, 30, 1);
        checkOutput("flush_pre_idle", idle, 0);
        out_en = 1'b1;
        flush  = 1'b1;
        applyStimulus(1'b1, 200, 5, 2);
        checkOutput("flush_plot", vga_plot, 0);
        checkOutput("flush_idle", idle, 1);
        checkOutput("flush_clip", clip_cnt, expClip);
        flush = 1'b0;
        applyStimulus(1'b0, 0, 0, 0);
        checkOutput("flush_after_plot", vga_plot, 0);
        checkOutput("flush_after_idle", idle, 1);

        // Reset asserted with five entries queued
        out_en = 1'b0;
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 40 + i, 50, 5);
        in_valid = 1'b0;
        checkOutput("mid_pre_idle", idle, 0);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("mid_reset_x", vga_x, 0);
        checkOutput("mid_reset_idle", idle, 1);
        checkOutput("mid_reset_ready", in_ready, 0);
        @(negedge clk);
        rst_n  = 1'b1;
        out_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 0, 0, 0);
            checkOutput($sformatf("mid_release_plot_%0d", i), vga_plot, 0);
        end
        checkOutput("mid_release_idle", idle, 1);
        checkOutput("mid_release_x", vga_x, 0);

        // Fillscreen streaming
        pulses = 0; readyLow = 0; streamBad = 0;
        firstX = -1; firstY = -1; lastX = -1; lastY = -1;
        for (int y = 0; y < 120; y++) begin
            for (int x = 0; x < 160; x++) begin
                if (!in_ready) readyLow++;
                applyStimulus(1'b1, x, y, (x + y) % 8);
                if (vga_plot) begin
                    sx = vga_x; sy = vga_y;
                    if (pulses == 0) begin firstX = sx; firstY = sy; end
                    lastX = sx; lastY = sy;
                    pulses++;
                end
                if (!vga_plot || vga_x != x[7:0] || vga_y != y[6:0]) streamBad++;
            end
        end
        applyStimulus(1'b0, 0, 0, 0);
        checkOutput("stream_pulses", pulses, 19200);
        checkOutput("stream_first_x", firstX, 0);
        checkOutput("stream_first_y", firstY, 0);
        checkOutput("stream_last_x", lastX, 159);
        checkOutput("stream_last_y", lastY, 119);
        checkOutput("stream_ready_low", readyLow, 0);
        checkOutput("stream_order", streamBad, 0);
        checkOutput("stream_end_idle", idle, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vga_plot_buffer.md
# vga_plot_buffer

Buffered, clipping plot interface between the drawing engines (fillscreen, circle/Reuleaux) and the VGA adapter. It accepts signed pixel requests over a valid/ready handshake and drops requests that fall outside the 160×120 screen. Surviving requests are queued in a small FIFO and drained at one plot per cycle onto the adapter's `VGA_X`/`VGA_Y`/`VGA_COLOUR`/`VGA_PLOT` inputs. Drawing engines wait for `idle` before reporting done, so the last plot is never lost.

## Interface
- `DEPTH`, 8, FIFO entries; power of two, ≥2.
- `SCREEN_W`, 160, visible width in pixels.
- `SCREEN_H`, 120, visible height in pixels.

- `clk`  in  1  system clock (CLOCK_50 domain).
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  plot request present.
- `in_x`  in  9  signed x coordinate.
- `in_y`  in  8  signed y coordinate.
- `in_colour`  in  3  pixel colour.
- `in_ready`  out  1  request accepted on an edge where `in_valid && in_ready`.
- `flush`  in  1  synchronous clear of queued plots.
- `out_en`  in  1  drain enable; 0 pauses output.
- `vga_x`  out  8  to adapter `VGA_X`.
- `vga_y`  out  7  to adapter `VGA_Y`.
- `vga_colour`  out  3  to adapter `VGA_COLOUR`.
- `vga_plot`  out  1  to adapter `VGA_PLOT`; high for exactly one cycle per plot.
- `idle`  out  1  FIFO empty and `vga_plot` low.
- `clip_cnt`  out  16  count of dropped requests; saturates at 16'hFFFF.

## Operation
- Accept: `in_ready = rst_n && (count < DEPTH)`. The value depends on `count` only, not on a same-cycle pop.
- Clip test: a request is on screen when `0 ≤ in_x < SCREEN_W` and `0 ≤ in_y < SCREEN_H`. Both comparisons are signed.
- An accepted off-screen request is consumed: it is not written, and `clip_cnt` increments.
- An accepted on-screen request is pushed as `{x[7:0], y[6:0], colour}`.
- Drain, evaluated each edge when `out_en = 1`:
  - If the FIFO is non-empty, pop the head into the output registers and set `vga_plot = 1`.
  - Else, if an on-screen request is accepted this edge, bypass it directly into the output registers and set `vga_plot = 1`. It is not written into the FIFO.
  - Otherwise set `vga_plot = 0`.
- When `out_en = 0`, `vga_plot = 0`. Output coordinates hold their last value.
- Ordering is strict FIFO. Bypass is only taken when the FIFO is empty.
- A simultaneous push and pop leaves `count` unchanged. Pointers wrap modulo `DEPTH`.
- `flush` takes priority over push and pop:
  - `count` goes to 0 and pointers go to 0.
  - `vga_plot` is 0 on the next cycle and the request presented that cycle is discarded.
  - `clip_cnt` is kept.
- Reset mid-operation discards all queued plots immediately.

## Timing
- Reset values: `vga_x = 0`, `vga_y = 0`, `vga_colour = 0`, `vga_plot = 0`, `clip_cnt = 0`, `in_ready = 0` while `rst_n` is low, `idle = 1`.
- Latency: a request accepted at edge N into an empty FIFO, with `out_en = 1`, shows `vga_plot = 1` in the cycle after edge N.
- Throughput: one plot per cycle. Sustained `in_valid` with `out_en = 1` never deasserts `in_ready`.
- Full: `count == DEPTH` forces `in_ready = 0` even if a pop occurs on the same edge.
- `idle` is combinational from registered state.

## Configuration
- `PLOT_CLIP_EN` defined: clipping and `clip_cnt` behave as described above.
- `PLOT_CLIP_EN` undefined:
  - No range test is performed.
  - Every accepted request is pushed with `x = in_x[7:0]` and `y = in_y[6:0]`.
  - `clip_cnt` is tied to 0.

## Structure
- Package `plot_pkg` holds:
  - `plot_t` packed struct `{x[7:0], y[6:0], colour[2:0]}`.
  - `SCREEN_W` and `SCREEN_H` constants, which the parameters default to.
  - Signed coordinate typedefs `coord_x_t` (9b) and `coord_y_t` (8b).
- Sub-module `plot_fifo`: synchronous FIFO of `plot_t` with `DEPTH`, push, pop, clear, count (`$clog2(DEPTH)+1` bits), full and empty. Clip logic, bypass and output registers stay in `vga_plot_buffer`.

## Test plan
- Reset mid-stream: reset with 5 entries queued, then release → outputs all 0, `idle = 1`, no `vga_plot` pulses.
- Single plot: (10,20,colour 3) accepted at edge N, `out_en = 1` → `vga_plot = 1` with `vga_x = 10`, `vga_y = 20`, `vga_colour = 3` in the cycle after edge N only, then `idle = 1`.
- Clipping, with `PLOT_CLIP_EN` defined: requests (-1,5), (160,5), (5,120), (159,119) → a single plot (159,119) is produced and `clip_cnt = 3`. With the macro undefined, (160,5) is plotted at x = 160 and `clip_cnt = 0`.
- Backpressure: `out_en = 0`, push 9 on-screen requests → 8 accepted and `in_ready = 0` at `count = 8`. Then set `out_en = 1` → 8 consecutive plots in push order, and `in_ready` returns to 1 the cycle after the first pop.
- Streaming: a fillscreen pattern of 19200 requests with `out_en = 1` → 19200 `vga_plot` pulses, the first at (0,0) and the last at (159,119), with `in_ready` never low.
- Flush: flush with 4 entries queued and `in_valid` high → next cycle `vga_plot = 0`, `idle = 1`, and `clip_cnt` unchanged.
